modport_fifo: RTL and testbench
===============================

Name: modport_fifo

Overview:
- Single-clock synchronous FIFO, 8-bit default data path, registered read data and status flags.
- Used as a generic buffering stage between a producer (wr/data_in) and a consumer (rd/data_out).
- Full/empty flags give back-pressure; the block ignores illegal requests without corrupting state.

Parameters:
- DATA_WIDTH, 8, width of data_in/data_out and of each storage entry.
- DEPTH, 16, number of entries; must be a power of two and at least 2.
- ADDR_WIDTH, $clog2(DEPTH), pointer width (derived; do not override).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- wr  input  1  write request; sampled on the rising edge.
- rd  input  1  read request; sampled on the rising edge.
- data_in  input  DATA_WIDTH  write data; captured when a write is accepted.
- data_out  output  DATA_WIDTH  registered read data.
- full  output  1  high when DEPTH entries are stored.
- empty  output  1  high when 0 entries are stored.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst). rst has priority over wr/rd in the same cycle.
- Internal state:
  - write pointer and read pointer, ADDR_WIDTH bits, wrapping modulo DEPTH;
  - occupancy count, ADDR_WIDTH+1 bits, range 0..DEPTH;
  - storage array of DEPTH x DATA_WIDTH.
- Reset (rst=1 at the edge):
  - pointers and count go to 0;
  - data_out=0, empty=1, full=0;
  - storage contents are not cleared.
- Write accept: wr=1 and (full=0 or rd=1). On accept, mem[wptr]<=data_in and wptr<=wptr+1 (wraps DEPTH-1 -> 0).
- Read accept: rd=1 and empty=0. On accept, data_out<=mem[rptr] and rptr<=rptr+1 (wraps).
  - Latency: data_out shows the oldest entry one edge after the read is sampled.
- Rejected requests:
  - Read on empty: no pointer change; data_out holds its previous value.
  - Write on full with rd=0: data dropped; no state change.
- Count update per edge:
  - +1 on write-only accept;
  - -1 on read-only accept;
  - unchanged when both are accepted or neither is.
- Simultaneous rd=1, wr=1:
  - empty: only the write is accepted, with no bypass to data_out. data_out holds; next cycle count=1, empty=0.
  - full: both are accepted; count stays DEPTH and full stays 1.
  - otherwise: both are accepted; count is unchanged.
- Flags are registered and reflect the post-edge count (empty = count==0, full = count==DEPTH), valid in the same cycle as the updated count. full and empty are never both 1.
- Ordering: strict first-in first-out, including across pointer wrap-around.
- Reset mid-operation: all stored data is discarded and the block restarts empty. Entries written before reset are never returned afterwards.
- No X propagation: data_out is driven only from reset or from written entries.

Test Plan:
- Reset: assert rst for 2 cycles with wr=rd=1 -> data_out=0x00, empty=1, full=0, and no write is recorded.
- Fill: write 0x00..0x0F on 16 consecutive cycles -> empty=0 after the first edge, full=1 after the 16th. A 17th write of 0xAA is ignored.
- Drain: read 16 times -> data_out=0x00..0x0F in order, one edge after each rd, empty=1 after the 16th read. A 17th read leaves data_out=0x0F.
- Wrap-around: write 10, read 10, then write 0x50..0x5B (12 entries) and read all -> 0x50..0x5B returned in order, empty=1 at the end.
- Simultaneous: with FIFO full of 0x00..0x0F, rd=wr=1 with data_in=0xC3 -> data_out=0x00, full stays 1. Draining then returns 0x01..0x0F followed by 0xC3.
  - Separately, on an empty FIFO, rd=wr=1 with data_in=0x77 -> data_out unchanged, empty=0. The next read returns 0x77.
- Reset mid-operation: write 0x11, 0x22, 0x33, pulse rst, then read -> empty=1 with data_out=0x00 on the read attempt. A new write of 0x44 then reads back as 0x44.

Source files
------------

// File: rtl/modport_fifo_if.sv
// Producer/consumer handshake bundle for modport_fifo.
// The master drives requests and write data; the slave (the FIFO) returns read data and flags.
interface modport_fifo_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  wr;
  logic                  rd;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  full;
  logic                  empty;

  modport master (
    output wr,
    output rd,
    output data_in,
    input  data_out,
    input  full,
    input  empty
  );

  modport slave (
    input  wr,
    input  rd,
    input  data_in,
    output data_out,
    output full,
    output empty
  );
endinterface

// File: rtl/modport_fifo.sv
// Single-clock FIFO with registered read data and registered full/empty flags.
// Illegal requests (read on empty, write on full without read) are ignored.
module modport_fifo #(
  parameter  int DATA_WIDTH = 8,
  parameter  int DEPTH      = 16,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input logic          clk,
  input logic          rst,
  modport_fifo_if.slave bus
);

  localparam logic [ADDR_WIDTH-1:0] PTR_ONE    = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH:0]   COUNT_FULL = (ADDR_WIDTH + 1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  wr_accept;
  logic                  rd_accept;

  // A full FIFO still takes a write when a read frees a slot in the same edge.
  assign wr_accept = bus.wr && (!bus.full || bus.rd);
  assign rd_accept = bus.rd && !bus.empty;

  always_comb begin
    count_next = count;
    case ({wr_accept, rd_accept})
      2'b10:   count_next = count + COUNT_ONE;
      2'b01:   count_next = count - COUNT_ONE;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr         <= '0;
      rptr         <= '0;
      count        <= '0;
      bus.data_out <= '0;
      bus.empty    <= 1'b1;
      bus.full     <= 1'b0;
    end else begin
      if (wr_accept) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_accept) begin
        rptr         <= rptr + PTR_ONE;
        bus.data_out <= mem[rptr];
      end
      count     <= count_next;
      bus.empty <= (count_next == '0);
      bus.full  <= (count_next == COUNT_FULL);
    end
  end

  // Storage is deliberately left out of reset; pointers alone define validity.
  always_ff @(posedge clk) begin
    if (!rst && wr_accept) begin
      mem[wptr] <= bus.data_in;
    end
  end

endmodule

// File: tb/tb_modport_fifo.sv
// Self-checking bench for modport_fifo: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_modport_fifo;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [DATA_WIDTH-1:0] model_q [$];
  logic [DATA_WIDTH-1:0] exp_data = '0;

  modport_fifo_if #(.DATA_WIDTH(DATA_WIDTH)) bus ();

  modport_fifo #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // One clock of stimulus; the model follows the FIFO rules on a plain queue.
  task automatic applyStimulus(input string tag, input logic r_rst, input logic w, input logic r,
                               input logic [DATA_WIDTH-1:0] d);
    bit rd_ok;
    bit wr_ok;
    rst         = r_rst;
    bus.wr      = w;
    bus.rd      = r;
    bus.data_in = d;
    @(posedge clk);
    if (r_rst) begin
      model_q.delete();
      exp_data = '0;
    end else begin
      rd_ok = r && (model_q.size() > 0);
      wr_ok = w && ((model_q.size() < DEPTH) || r);
      if (rd_ok) exp_data = model_q.pop_front();
      if (wr_ok) model_q.push_back(d);
    end
    #1;
    checkOutput({tag, ".data_out"}, 32'(bus.data_out), 32'(exp_data));
    checkOutput({tag, ".empty"}, 32'(bus.empty), 32'(model_q.size() == 0));
    checkOutput({tag, ".full"}, 32'(bus.full), 32'(model_q.size() == DEPTH));
  endtask

  initial begin
    int wr_pct;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.data_in = '0;

    $display("[TB] reset with wr=rd=1");
    applyStimulus("reset", 1'b1, 1'b1, 1'b1, 8'h5A);
    applyStimulus("reset", 1'b1, 1'b1, 1'b1, 8'h5A);

    $display("[TB] fill and overflow");
    for (int i = 0; i < DEPTH; i++) applyStimulus("fill", 1'b0, 1'b1, 1'b0, 8'(i));
    applyStimulus("overflow", 1'b0, 1'b1, 1'b0, 8'hAA);

    $display("[TB] drain and underflow");
    for (int i = 0; i < DEPTH; i++) applyStimulus("drain", 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("underflow", 1'b0, 1'b0, 1'b1, 8'h00);

    $display("[TB] wrap-around");
    for (int i = 0; i < 10; i++) applyStimulus("wrap_wr", 1'b0, 1'b1, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) applyStimulus("wrap_rd", 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 12; i++) applyStimulus("wrap_wr2", 1'b0, 1'b1, 1'b0, 8'(8'h50 + i));
    for (int i = 0; i < 12; i++) applyStimulus("wrap_rd2", 1'b0, 1'b0, 1'b1, 8'h00);

    $display("[TB] simultaneous on full");
    for (int i = 0; i < DEPTH; i++) applyStimulus("sim_fill", 1'b0, 1'b1, 1'b0, 8'(i));
    applyStimulus("sim_full", 1'b0, 1'b1, 1'b1, 8'hC3);
    for (int i = 0; i < DEPTH + 1; i++) applyStimulus("sim_drain", 1'b0, 1'b0, 1'b1, 8'h00);

    $display("[TB] simultaneous on empty");
    applyStimulus("sim_empty", 1'b0, 1'b1, 1'b1, 8'h77);
    applyStimulus("sim_empty_rd", 1'b0, 1'b0, 1'b1, 8'h00);

    $display("[TB] reset mid-operation");
    applyStimulus("mid_wr", 1'b0, 1'b1, 1'b0, 8'h11);
    applyStimulus("mid_wr", 1'b0, 1'b1, 1'b0, 8'h22);
    applyStimulus("mid_wr", 1'b0, 1'b1, 1'b0, 8'h33);
    applyStimulus("mid_rst", 1'b1, 1'b0, 1'b0, 8'h00);
    applyStimulus("mid_rd", 1'b0, 1'b0, 1'b1, 8'h00);
    applyStimulus("mid_wr2", 1'b0, 1'b1, 1'b0, 8'h44);
    applyStimulus("mid_rd2", 1'b0, 1'b0, 1'b1, 8'h00);

    $display("[TB] random traffic");
    for (int blk = 0; blk < 4; blk++) begin
      wr_pct = (blk == 0) ? 70 : (blk == 1) ? 30 : (blk == 2) ? 50 : 90;
      for (int i = 0; i < 100; i++) begin
        applyStimulus("random",
                      ($urandom_range(0, 49) == 0),
                      ($urandom_range(0, 99) < wr_pct),
                      ($urandom_range(0, 99) < (100 - wr_pct)),
                      8'($urandom));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
